// File: rtl/motor_step_gen.sv
// Step/direction pulse generator for a stepper motor driver.
// A command supplies a pulse count, a direction and a rise-to-rise period.
// The block holds dir stable for a setup time, then issues fixed-width step
// pulses at the requested period. An abort ends the run cleanly without
// producing a runt pulse.
module motor_step_gen #(
  parameter int PULSE_W   = 50,
  parameter int DIR_SETUP = 10,
  parameter int CNT_W     = 16,
  parameter int PER_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;

  // A zero setup time still needs one cycle so dir settles before step rises.
  localparam int SETUP_CYC = (DIR_SETUP < 1) ? 1 : DIR_SETUP;

  // Timing constants widened to the counter width, one bit wider than the
  // period so that PULSE_W+1 cannot wrap when it is compared or subtracted.
  localparam logic [PER_W:0] PW_PLUS1   = (PER_W+1)'(PULSE_W + 1);
  localparam logic [PER_W:0] SETUP_LAST = (PER_W+1)'(SETUP_CYC - 1);
  localparam logic [PER_W:0] HIGH_LAST  = (PER_W+1)'(PULSE_W - 1);

  state_t           state_q, state_d;
  logic [PER_W:0]   cnt_q, cnt_d;
  logic [PER_W:0]   period_q, period_d;
  logic [CNT_W-1:0] steps_left_q, steps_left_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic             abort_pend_q, abort_pend_d;

  logic [PER_W:0]   eff_period;
  logic [PER_W:0]   low_last;

  // Clamp the requested period so every low phase lasts at least one cycle.
  assign eff_period = ({1'b0, cmd_period} < PW_PLUS1) ? PW_PLUS1 : {1'b0, cmd_period};

  // Terminal count for the low phase: P - PULSE_W cycles, counted down to 0.
  assign low_last = period_q - PW_PLUS1;

  // Next-state logic: phase sequencing, pulse counting and abort handling.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    steps_left_d = steps_left_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    abort_pend_d = abort_pend_q;

    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (cmd_valid) begin
          dir_d        = cmd_dir;
          steps_left_d = cmd_steps;
          period_d     = eff_period;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LAST;
          end
        end
      end

      SETUP: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = HIGH_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      HIGH: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (cnt_q == '0) begin
          steps_left_d = steps_left_q - 1'b1;
          if (abort_pend_q || abort) begin
            state_d      = IDLE;
            done_d       = 1'b1;
            abort_pend_d = 1'b0;
          end else begin
            state_d = LOW;
            cnt_d   = low_last;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      LOW: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          if (steps_left_q != '0) begin
            state_d = HIGH;
            cnt_d   = HIGH_LAST;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    step_d = (state_d == HIGH);
  end

  // State and output registers; reset clears everything, so no done follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      steps_left_q <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      steps_left_q <= steps_left_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign step       = step_q;
  assign dir        = dir_q;
  assign done       = done_q;
  assign steps_left = steps_left_q;

endmodule

// File: tb/tb_motor_step_gen.sv
// Self-checking bench for motor_step_gen (PULSE_W=4, DIR_SETUP=3).
// A timeline model predicts every output from the command's acceptance time,
// pulse count and clamped period; directed scenarios add literal checks.
module tb_motor_step_gen;

  localparam int PW    = 4;
  localparam int DS    = 3;
  localparam int S     = 3;
  localparam int CW    = 16;
  localparam int PERW  = 24;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [CW-1:0]   cmd_steps = '0;
  logic            cmd_dir = 1'b0;
  logic [PERW-1:0] cmd_period = '0;
  logic            abort = 1'b0;
  logic            step;
  logic            dir;
  logic            busy;
  logic            done;
  logic [CW-1:0]   steps_left;

  int checks = 0;
  int failures = 0;

  // Model state: command timeline relative to its acceptance edge.
  int cyc = 0;
  int accCyc = 0;
  int mN = 0;
  int mP = 0;
  int mEnd = 0;
  bit mHave = 1'b0;
  bit mDir = 1'b0;
  int tPrev, phPrev, uPrev, perReq;
  int cT, cPh;

  // Pulse-shape monitor state.
  int rises = 0;
  int doneCount = 0;
  int hiRun = 0;
  int loRun = 0;
  int lastHigh = 0;
  int lastLow = 0;
  bit prevStep = 1'b0;

  int r0, d0;

  motor_step_gen #(
    .PULSE_W(PW),
    .DIR_SETUP(DS),
    .CNT_W(CW),
    .PER_W(PERW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .cmd_dir(cmd_dir),
    .cmd_period(cmd_period),
    .abort(abort),
    .step(step),
    .dir(dir),
    .busy(busy),
    .done(done),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  // Phase of cycle t after acceptance: 0 idle, 1 setup, 2 high, 3 low.
  function automatic int phaseAt(input int t);
    int u;
    if (!mHave || t < 1 || t > mEnd) return 0;
    if (t <= S) return 1;
    u = t - S - 1;
    return ((u % mP) < PW) ? 2 : 3;
  endfunction

  // Pulses remaining at cycle t: each pulse counts once its high phase ends.
  function automatic int stepsLeftAt(input int t);
    int x, c;
    if (!mHave) return 0;
    x = (t < mEnd + 1) ? t : mEnd + 1;
    if (x < S + PW + 1) return mN;
    c = (x - S - PW - 1) / mP + 1;
    if (c > mN) c = mN;
    return mN - c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each edge: acceptance in idle, abort shortens the timeline.
  always @(posedge clk) begin
    if (rst_n) begin
      tPrev  = cyc - accCyc;
      phPrev = phaseAt(tPrev);
      if (phPrev == 0) begin
        if (cmd_valid) begin
          mHave  = 1'b1;
          accCyc = cyc;
          mN     = int'(cmd_steps);
          perReq = int'(cmd_period);
          mP     = (perReq < PW + 1) ? PW + 1 : perReq;
          mDir   = cmd_dir;
          mEnd   = (mN == 0) ? 0 : S + mN * mP;
        end
      end else if (abort) begin
        if (phPrev == 2) begin
          uPrev = tPrev - S - 1;
          mEnd  = S + (uPrev / mP) * mP + PW;
        end else begin
          mEnd = tPrev;
        end
      end
    end
    cyc++;
  end

  // Reset discards any command in the model, so no done is expected after it.
  always @(negedge rst_n) begin
    mHave = 1'b0;
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    cT  = cyc - accCyc;
    cPh = phaseAt(cT);
    checkOutput("step", 32'(step), 32'(cPh == 2));
    checkOutput("busy", 32'(busy), 32'(cPh != 0));
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(cPh == 0));
    checkOutput("done", 32'(done), 32'(mHave && cT == mEnd + 1));
    checkOutput("dir", 32'(dir), 32'(mHave ? mDir : 1'b0));
    checkOutput("steps_left", 32'(steps_left), 32'(stepsLeftAt(cT)));
  end

  // Track pulse count, high/low run lengths and done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      hiRun = 0;
      loRun = 0;
      prevStep = 1'b0;
    end else begin
      if (step && !prevStep) begin
        rises++;
        lastLow = loRun;
        loRun = 0;
      end
      if (!step && prevStep) begin
        lastHigh = hiRun;
        hiRun = 0;
      end
      if (step) hiRun++;
      else if (busy) loRun++;
      else loRun = 0;
      if (done) doneCount++;
      prevStep = step;
    end
  end

  task automatic applyStimulus(input int steps, input bit d, input int per, input bit ab);
    @(posedge clk);
    #2;
    cmd_valid  = 1'b1;
    cmd_steps  = CW'(steps);
    cmd_dir    = d;
    cmd_period = PERW'(per);
    abort      = ab;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL waitIdle: busy still 1 after %0d cycles", budget);
    end
  endtask

  task automatic waitRises(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (rises >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL waitRises: got %0d rises expected %0d", rises, target);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios with literal expectations.
  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst step", 32'(step), 0);
    checkOutput("rst dir", 32'(dir), 0);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst done", 32'(done), 0);
    checkOutput("rst ready", 32'(cmd_ready), 1);
    checkOutput("rst steps_left", 32'(steps_left), 0);

    // Three pulses, dir=1, period 10.
    r0 = rises;
    d0 = doneCount;
    applyStimulus(3, 1'b1, 10, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t1 dir", 32'(dir), 1);
    checkOutput("t1 busy", 32'(busy), 1);
    checkOutput("t1 steps_left", 32'(steps_left), 3);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("t1 step before rise", 32'(step), 0);
    @(negedge clk);
    #1;
    checkOutput("t1 step first rise", 32'(step), 1);
    waitIdle(60);
    settle();
    checkOutput("t1 rises", 32'(rises - r0), 3);
    checkOutput("t1 high width", 32'(lastHigh), 4);
    checkOutput("t1 low width", 32'(lastLow), 6);
    checkOutput("t1 done count", 32'(doneCount - d0), 1);
    checkOutput("t1 steps_left end", 32'(steps_left), 0);
    checkOutput("t1 ready end", 32'(cmd_ready), 1);

    // Zero steps: done only.
    r0 = rises;
    d0 = doneCount;
    applyStimulus(0, 1'b0, 10, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t2 done", 32'(done), 1);
    checkOutput("t2 busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    checkOutput("t2 done drop", 32'(done), 0);
    checkOutput("t2 rises", 32'(rises - r0), 0);

    // Period clamp: 2 requested, 5 effective.
    r0 = rises;
    applyStimulus(2, 1'b1, 2, 1'b0);
    waitIdle(40);
    settle();
    checkOutput("t3 rises", 32'(rises - r0), 2);
    checkOutput("t3 high width", 32'(lastHigh), 4);
    checkOutput("t3 low width", 32'(lastLow), 1);

    // Abort during the second high phase.
    r0 = rises;
    d0 = doneCount;
    applyStimulus(5, 1'b0, 10, 1'b0);
    waitRises(r0 + 2, 60);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    waitIdle(20);
    repeat (15) settle();
    checkOutput("t4 rises", 32'(rises - r0), 2);
    checkOutput("t4 high width", 32'(lastHigh), 4);
    checkOutput("t4 steps_left", 32'(steps_left), 3);
    checkOutput("t4 done count", 32'(doneCount - d0), 1);

    // Abort during setup.
    r0 = rises;
    d0 = doneCount;
    applyStimulus(4, 1'b1, 8, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #2 abort = 1'b0;
    waitIdle(10);
    repeat (10) settle();
    checkOutput("t5 rises", 32'(rises - r0), 0);
    checkOutput("t5 steps_left", 32'(steps_left), 4);
    checkOutput("t5 done count", 32'(doneCount - d0), 1);

    // Abort during a low phase.
    r0 = rises;
    applyStimulus(3, 1'b0, 10, 1'b0);
    waitRises(r0 + 1, 20);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    waitIdle(20);
    repeat (12) settle();
    checkOutput("t6 rises", 32'(rises - r0), 1);
    checkOutput("t6 steps_left", 32'(steps_left), 2);

    // Abort in idle alongside a command: command still runs.
    r0 = rises;
    applyStimulus(1, 1'b1, 6, 1'b1);
    waitIdle(30);
    settle();
    checkOutput("t7 rises", 32'(rises - r0), 1);
    checkOutput("t7 dir", 32'(dir), 1);

    // Reset during a high phase.
    r0 = rises;
    applyStimulus(3, 1'b1, 10, 1'b0);
    waitRises(r0 + 1, 20);
    d0 = doneCount;
    rst_n = 1'b0;
    #1;
    checkOutput("t8 async step", 32'(step), 0);
    checkOutput("t8 async busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) settle();
    checkOutput("t8 no done", 32'(doneCount - d0), 0);
    checkOutput("t8 dir", 32'(dir), 0);
    r0 = rises;
    applyStimulus(2, 1'b0, 7, 1'b0);
    waitIdle(40);
    settle();
    checkOutput("t8 rises after reset", 32'(rises - r0), 2);
    checkOutput("t8 steps_left", 32'(steps_left), 0);

    repeat (3) settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a scenario stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/motor_step_gen.md
MOTOR_STEP_GEN -- requirements
Module: motor_step_gen

Interface
REQ-001 Parameter: PULSE_W, default 50, step high width in clk cycles (>=1).
REQ-002 Parameter: DIR_SETUP, default 10, cycles dir is stable before the first step rise.
REQ-003 Parameter: CNT_W, default 16, width of the step count.
REQ-004 Parameter: PER_W, default 24, width of the step period.
REQ-005 Port: clk  in  1  clock; all state changes occur on its rising edge.
REQ-006 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: cmd_valid  in  1  command offered.
REQ-008 Port: cmd_ready  out  1  block can accept a command.
REQ-009 Port: cmd_steps  in  CNT_W  number of step pulses to issue.
REQ-010 Port: cmd_dir  in  1  motor direction for the command.
REQ-011 Port: cmd_period  in  PER_W  clk cycles from one step rise to the next.
REQ-012 Port: abort  in  1  request early termination.
REQ-013 Port: step  out  1  registered step pulse to the motor driver.
REQ-014 Port: dir  out  1  registered direction to the motor driver.
REQ-015 Port: busy  out  1  command in progress.
REQ-016 Port: done  out  1  one-cycle completion pulse.
REQ-017 Port: steps_left  out  CNT_W  pulses not yet completed.

Function
REQ-018 The FSM SHALL use states IDLE, SETUP, HIGH and LOW; cmd_ready SHALL be 1 only in IDLE.
REQ-019 A command SHALL be accepted on an edge where cmd_valid and cmd_ready are both 1; steps, dir and period SHALL be latched, and dir and steps_left SHALL update on that edge.
REQ-020 Effective period P SHALL be max(cmd_period, PULSE_W+1), so every low phase lasts at least 1 cycle.
REQ-021 With cmd_steps=0, the block SHALL emit no pulse, stay in IDLE, keep busy at 0 and assert done for the cycle after acceptance.
REQ-022 Otherwise the FSM SHALL enter SETUP for S=max(DIR_SETUP,1) cycles, so step first rises S edges after the acceptance edge.
REQ-023 In HIGH, step SHALL be 1 for exactly PULSE_W cycles; steps_left SHALL decrement by 1 on the edge leaving HIGH.
REQ-024 In LOW, step SHALL be 0 for P-PULSE_W cycles; then the FSM SHALL go to HIGH if steps_left>0, else to IDLE.
REQ-025 On each return to IDLE, done SHALL pulse high for exactly one cycle: the first IDLE cycle.
REQ-026 abort in SETUP or LOW SHALL force IDLE on the next edge, with done asserted and no further pulses.
REQ-027 abort in HIGH SHALL let the current pulse complete its full PULSE_W (no runt), decrement steps_left, and then enter IDLE with done.
REQ-028 abort in IDLE SHALL be ignored; a command offered in the same cycle SHALL be accepted.
REQ-029 busy SHALL be 1 exactly when the state is not IDLE.
REQ-030 dir and steps_left SHALL hold their values after completion or abort until the next acceptance.
REQ-031 step and dir SHALL be driven straight from flops, with no combinational glitches.
REQ-032 The period counter SHALL be PER_W+1 bits wide so the clamp cannot overflow.

Reset
REQ-033 While rst_n=0, the outputs SHALL be: step=0, dir=0, busy=0, done=0, steps_left=0, state IDLE, cmd_ready=1.
REQ-034 Reset asserted mid-command SHALL drop step immediately, with no done pulse after release.

Verification (PULSE_W=4, DIR_SETUP=3)
REQ-035 Reset release -> step=0, dir=0, busy=0, done=0, cmd_ready=1, steps_left=0.
REQ-036 steps=3, dir=1, period=10 -> dir=1 and busy=1 after the acceptance edge; step first rises 3 edges later; 3 pulses of 4 high and 6 low; one done pulse; steps_left=0; cmd_ready back to 1.
REQ-037 steps=0 -> no step activity; busy stays 0; done high for one cycle after acceptance.
REQ-038 steps=2, period=2 -> period clamped to 5: 4 cycles high, 1 cycle low, per pulse.
REQ-039 steps=5, abort during the 2nd HIGH -> that pulse lasts the full 4 cycles; steps_left=3; done pulses; no further step rise.
REQ-040 rst_n low during HIGH -> step=0 asynchronously; after release, IDLE, no done pulse, next command runs normally.
